// File: rtl/srio_pkg.sv
// Shared SRIO definitions: HELLO header field positions, FTYPE codes and the
// steering FSM state type.
package srio_pkg;

  localparam int FTYPE_HI = 55;
  localparam int FTYPE_LO = 52;
  localparam int TTYPE_HI = 51;
  localparam int TTYPE_LO = 48;
  localparam int SIZE_HI  = 43;
  localparam int SIZE_LO  = 36;
  localparam int ADDR_HI  = 33;
  localparam int ADDR_LO  = 0;

  localparam logic [3:0] FTYPE_NREAD    = 4'd2;
  localparam logic [3:0] FTYPE_NWRITE   = 4'd5;
  localparam logic [3:0] FTYPE_SWRITE   = 4'd6;
  localparam logic [3:0] FTYPE_DOORBELL = 4'd10;
  localparam logic [3:0] FTYPE_MESSAGE  = 4'd11;

  typedef enum logic [1:0] {
    ST_HDR      = 2'd0,
    ST_SW_BODY  = 2'd1,
    ST_OTH_BODY = 2'd2
  } steer_state_e;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } axis_beat_t;

endpackage

// File: rtl/srio_axis_reg.sv
// One-deep AXI-stream pipeline register (64-bit data + last) with valid/ready.
// Contents stay stable while out_valid is high and out_ready is low.
module srio_axis_reg
  import srio_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  axis_beat_t in_beat,
  output logic       in_ready,
  output logic       out_valid,
  output axis_beat_t out_beat,
  input  logic       out_ready
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_beat <= in_beat;
    end
  end

endmodule

// File: rtl/srio_swrite_steer.sv
// Steers whole HELLO packets: FTYPE==SWRITE_FTYPE to M_SW, everything else to M_OTH.
// Optional SWRITE length checking is enabled by defining SRIO_SWRITE_STEER_LENCHK_EN.
module srio_swrite_steer
  import srio_pkg::*;
#(
  parameter logic [3:0] SWRITE_FTYPE = 4'h6,
  parameter int         CNT_W        = 16
) (
  input  logic             AXIS_ACLK,
  input  logic             AXIS_ARESET,
  input  logic [63:0]      S_AXIS_TDATA,
  input  logic             S_AXIS_TVALID,
  input  logic             S_AXIS_TLAST,
  output logic             S_AXIS_TREADY,
  output logic [63:0]      M_SW_AXIS_TDATA,
  output logic             M_SW_AXIS_TVALID,
  output logic             M_SW_AXIS_TLAST,
  input  logic             M_SW_AXIS_TREADY,
  output logic [63:0]      M_OTH_AXIS_TDATA,
  output logic             M_OTH_AXIS_TVALID,
  output logic             M_OTH_AXIS_TLAST,
  input  logic             M_OTH_AXIS_TREADY,
  output logic [CNT_W-1:0] sw_pkt_cnt,
  output logic [CNT_W-1:0] oth_pkt_cnt,
  output logic [CNT_W-1:0] len_err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  steer_state_e state, state_nxt;
  logic         hdr_is_sw, sel_sw, acc, sw_rdy, oth_rdy;
  axis_beat_t   in_beat, sw_beat, oth_beat;

  assign hdr_is_sw = (S_AXIS_TDATA[FTYPE_HI:FTYPE_LO] == SWRITE_FTYPE);
  assign in_beat   = '{data: S_AXIS_TDATA, last: S_AXIS_TLAST};

  // Destination is kept separate from the FSM so ready/accept do not loop back into it.
  always_comb begin
    sel_sw = 1'b0;
    case (state)
      ST_HDR:      sel_sw = hdr_is_sw;
      ST_SW_BODY:  sel_sw = 1'b1;
      default:     sel_sw = 1'b0;
    endcase
  end

  assign S_AXIS_TREADY = !AXIS_ARESET && (sel_sw ? sw_rdy : oth_rdy);
  assign acc           = S_AXIS_TVALID && S_AXIS_TREADY;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HDR:
        if (acc && !S_AXIS_TLAST) state_nxt = hdr_is_sw ? ST_SW_BODY : ST_OTH_BODY;
      ST_SW_BODY, ST_OTH_BODY:
        if (acc && S_AXIS_TLAST) state_nxt = ST_HDR;
      default:
        state_nxt = ST_HDR;
    endcase
  end

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) state <= ST_HDR;
    else             state <= state_nxt;
  end

  srio_axis_reg u_sw_reg (
    .clk       (AXIS_ACLK),
    .rst       (AXIS_ARESET),
    .in_valid  (S_AXIS_TVALID && sel_sw),
    .in_beat   (in_beat),
    .in_ready  (sw_rdy),
    .out_valid (M_SW_AXIS_TVALID),
    .out_beat  (sw_beat),
    .out_ready (M_SW_AXIS_TREADY)
  );

  srio_axis_reg u_oth_reg (
    .clk       (AXIS_ACLK),
    .rst       (AXIS_ARESET),
    .in_valid  (S_AXIS_TVALID && !sel_sw),
    .in_beat   (in_beat),
    .in_ready  (oth_rdy),
    .out_valid (M_OTH_AXIS_TVALID),
    .out_beat  (oth_beat),
    .out_ready (M_OTH_AXIS_TREADY)
  );

  assign M_SW_AXIS_TDATA  = sw_beat.data;
  assign M_SW_AXIS_TLAST  = sw_beat.last;
  assign M_OTH_AXIS_TDATA = oth_beat.data;
  assign M_OTH_AXIS_TLAST = oth_beat.last;

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      sw_pkt_cnt  <= '0;
      oth_pkt_cnt <= '0;
    end else if (acc && S_AXIS_TLAST) begin
      if (sel_sw) begin
        if (sw_pkt_cnt != CNT_MAX) sw_pkt_cnt <= sw_pkt_cnt + CNT_W'(1);
      end else begin
        if (oth_pkt_cnt != CNT_MAX) oth_pkt_cnt <= oth_pkt_cnt + CNT_W'(1);
      end
    end
  end

`ifdef SRIO_SWRITE_STEER_LENCHK_EN
  // Up to 256 bytes -> at most 32 payload beats; 6 bits holds 0..32.
  logic [5:0] beat_cnt, exp_beats;
  logic       len_bad;

  assign exp_beats = {1'b0, S_AXIS_TDATA[SIZE_HI:SIZE_LO+3]} + 6'd1;

  always_comb begin
    len_bad = 1'b0;
    if (acc && S_AXIS_TLAST) begin
      if (state == ST_HDR && hdr_is_sw) len_bad = (exp_beats != 6'd0);
      else if (state == ST_SW_BODY)     len_bad = (beat_cnt != 6'd1);
    end
  end

  // Decrement saturates at 0 so an over-long packet cannot wrap back to 1.
  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      beat_cnt    <= '0;
      len_err_cnt <= '0;
    end else begin
      if (acc && state == ST_HDR && hdr_is_sw)
        beat_cnt <= exp_beats;
      else if (acc && state == ST_SW_BODY && beat_cnt != 6'd0)
        beat_cnt <= beat_cnt - 6'd1;
      if (len_bad && len_err_cnt != CNT_MAX)
        len_err_cnt <= len_err_cnt + CNT_W'(1);
    end
  end
`else
  assign len_err_cnt = '0;
`endif

endmodule

// File: tb/tb_srio_swrite_steer.sv
// Randomized bench for srio_swrite_steer against a packet-level reference model.
module tb_srio_swrite_steer;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] SAT = '1;

  logic             clk = 1'b0;
  logic             AXIS_ARESET;
  logic [63:0]      S_AXIS_TDATA;
  logic             S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TREADY;
  logic [63:0]      M_SW_AXIS_TDATA, M_OTH_AXIS_TDATA;
  logic             M_SW_AXIS_TVALID, M_SW_AXIS_TLAST, M_SW_AXIS_TREADY;
  logic             M_OTH_AXIS_TVALID, M_OTH_AXIS_TLAST, M_OTH_AXIS_TREADY;
  logic [CNT_W-1:0] sw_pkt_cnt, oth_pkt_cnt, len_err_cnt;

  srio_swrite_steer #(.SWRITE_FTYPE(4'h6), .CNT_W(CNT_W)) dut (
    .AXIS_ACLK         (clk),
    .AXIS_ARESET       (AXIS_ARESET),
    .S_AXIS_TDATA      (S_AXIS_TDATA),
    .S_AXIS_TVALID     (S_AXIS_TVALID),
    .S_AXIS_TLAST      (S_AXIS_TLAST),
    .S_AXIS_TREADY     (S_AXIS_TREADY),
    .M_SW_AXIS_TDATA   (M_SW_AXIS_TDATA),
    .M_SW_AXIS_TVALID  (M_SW_AXIS_TVALID),
    .M_SW_AXIS_TLAST   (M_SW_AXIS_TLAST),
    .M_SW_AXIS_TREADY  (M_SW_AXIS_TREADY),
    .M_OTH_AXIS_TDATA  (M_OTH_AXIS_TDATA),
    .M_OTH_AXIS_TVALID (M_OTH_AXIS_TVALID),
    .M_OTH_AXIS_TLAST  (M_OTH_AXIS_TLAST),
    .M_OTH_AXIS_TREADY (M_OTH_AXIS_TREADY),
    .sw_pkt_cnt        (sw_pkt_cnt),
    .oth_pkt_cnt       (oth_pkt_cnt),
    .len_err_cnt       (len_err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

`ifdef SRIO_SWRITE_STEER_LENCHK_EN
  localparam bit LENCHK = 1'b1;
`else
  localparam bit LENCHK = 1'b0;
`endif

  // Reference model: packet parse state, per-output expected beat queues, counters.
  logic [64:0] sw_q[$], oth_q[$];
  bit          m_in_hdr = 1'b1;
  bit          m_dest_sw;
  int          m_sw = 0, m_oth = 0, m_err = 0, m_pay = 0, m_exp = 0;
  bit          p_acc_sw, p_acc_oth, p_sw_stall, p_oth_stall;
  logic [64:0] p_sw_word, p_oth_word;

  function automatic int sat(input int v);
    return (v >= int'(SAT)) ? int'(SAT) : v + 1;
  endfunction

  always @(negedge clk) begin
    logic [64:0] e;
    bit          d_sw, rdy_exp;
    if (AXIS_ARESET) begin
      chk("rst_tready", S_AXIS_TREADY, 0);
      chk("rst_sw_vld", M_SW_AXIS_TVALID, 0);
      chk("rst_oth_vld", M_OTH_AXIS_TVALID, 0);
      chk("rst_sw_word", {M_SW_AXIS_TLAST, M_SW_AXIS_TDATA}, 0);
      chk("rst_oth_word", {M_OTH_AXIS_TLAST, M_OTH_AXIS_TDATA}, 0);
      chk("rst_cnts", {sw_pkt_cnt, oth_pkt_cnt, len_err_cnt}, 0);
      sw_q.delete(); oth_q.delete();
      m_in_hdr = 1; m_sw = 0; m_oth = 0; m_err = 0;
      p_acc_sw = 0; p_acc_oth = 0; p_sw_stall = 0; p_oth_stall = 0;
    end else begin
      chk("sw_pkt_cnt", sw_pkt_cnt, m_sw);
      chk("oth_pkt_cnt", oth_pkt_cnt, m_oth);
      chk("len_err_cnt", len_err_cnt, m_err);
      if (p_acc_sw)  chk("lat_sw", M_SW_AXIS_TVALID, 1);
      if (p_acc_oth) chk("lat_oth", M_OTH_AXIS_TVALID, 1);
      if (p_sw_stall) begin
        chk("hold_sw_vld", M_SW_AXIS_TVALID, 1);
        chk("hold_sw_word", {M_SW_AXIS_TLAST, M_SW_AXIS_TDATA}, p_sw_word);
      end
      if (p_oth_stall) begin
        chk("hold_oth_vld", M_OTH_AXIS_TVALID, 1);
        chk("hold_oth_word", {M_OTH_AXIS_TLAST, M_OTH_AXIS_TDATA}, p_oth_word);
      end
      if (M_SW_AXIS_TVALID && M_SW_AXIS_TREADY) begin
        if (sw_q.size() == 0) chk("sw_unexpected_beat", 1, 0);
        else begin e = sw_q.pop_front(); chk("sw_word", {M_SW_AXIS_TLAST, M_SW_AXIS_TDATA}, e); end
      end
      if (M_OTH_AXIS_TVALID && M_OTH_AXIS_TREADY) begin
        if (oth_q.size() == 0) chk("oth_unexpected_beat", 1, 0);
        else begin e = oth_q.pop_front(); chk("oth_word", {M_OTH_AXIS_TLAST, M_OTH_AXIS_TDATA}, e); end
      end
      d_sw    = m_in_hdr ? (S_AXIS_TDATA[55:52] == 4'd6) : m_dest_sw;
      rdy_exp = d_sw ? (!M_SW_AXIS_TVALID || M_SW_AXIS_TREADY)
                     : (!M_OTH_AXIS_TVALID || M_OTH_AXIS_TREADY);
      chk("s_tready", S_AXIS_TREADY, rdy_exp);
      p_acc_sw = 0; p_acc_oth = 0;
      if (S_AXIS_TVALID && S_AXIS_TREADY) begin
        if (m_in_hdr) begin
          m_dest_sw = d_sw;
          m_exp = (int'(S_AXIS_TDATA[43:36]) >> 3) + 1;
          m_pay = 0;
          if (d_sw && S_AXIS_TLAST && LENCHK) m_err = sat(m_err);
        end else if (m_dest_sw) begin
          m_pay++;
          if (S_AXIS_TLAST && LENCHK && m_pay != m_exp) m_err = sat(m_err);
        end
        if (d_sw) begin sw_q.push_back({S_AXIS_TLAST, S_AXIS_TDATA}); p_acc_sw = 1; end
        else      begin oth_q.push_back({S_AXIS_TLAST, S_AXIS_TDATA}); p_acc_oth = 1; end
        if (S_AXIS_TLAST) begin
          if (d_sw) m_sw = sat(m_sw); else m_oth = sat(m_oth);
        end
        m_in_hdr = S_AXIS_TLAST;
      end
      p_sw_stall  = M_SW_AXIS_TVALID && !M_SW_AXIS_TREADY;
      p_oth_stall = M_OTH_AXIS_TVALID && !M_OTH_AXIS_TREADY;
      p_sw_word   = {M_SW_AXIS_TLAST, M_SW_AXIS_TDATA};
      p_oth_word  = {M_OTH_AXIS_TLAST, M_OTH_AXIS_TDATA};
    end
  end

  // Output ready patterns: 0 always ready, 1 random, 2 SW toggles 1,0,0,1.
  int rdy_mode = 0;
  int tog_i = 0;
  initial begin M_SW_AXIS_TREADY = 1; M_OTH_AXIS_TREADY = 1; end
  always @(posedge clk) begin
    #1;
    tog_i = (tog_i + 1) % 4;
    case (rdy_mode)
      1: begin
        M_SW_AXIS_TREADY  = ($urandom_range(0, 3) != 0);
        M_OTH_AXIS_TREADY = ($urandom_range(0, 3) != 0);
      end
      2: begin
        M_SW_AXIS_TREADY  = (tog_i == 0 || tog_i == 3);
        M_OTH_AXIS_TREADY = 1;
      end
      default: begin M_SW_AXIS_TREADY = 1; M_OTH_AXIS_TREADY = 1; end
    endcase
  end

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] mk_hdr(input logic [3:0] ft, input logic [7:0] size);
    logic [63:0] d;
    d = rnd64();
    d[55:52] = ft;
    d[43:36] = size;
    return d;
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic l);
    bit ok;
    int n;
    n = 0;
    S_AXIS_TVALID = 1; S_AXIS_TDATA = d; S_AXIS_TLAST = l;
    do begin
      @(negedge clk); ok = S_AXIS_TREADY;
      @(posedge clk); #1; n++;
    end while (!ok && n < 200);
    if (!ok) chk("tready_timeout", 0, 1);
    S_AXIS_TVALID = 0;
  endtask

  task automatic send_pkt(input logic [3:0] ft, input logic [7:0] size, input int npay, input int gap);
    send_beat(mk_hdr(ft, size), npay == 0);
    for (int i = 0; i < npay; i++) send_beat(rnd64(), i == npay - 1);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(input int cycles);
    S_AXIS_TVALID = 0;
    AXIS_ARESET = 1;
    repeat (cycles) begin @(posedge clk); #1; end
    AXIS_ARESET = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rdy_mode = 0;
    while ((sw_q.size() != 0 || oth_q.size() != 0) && n < 100) begin @(posedge clk); #1; n++; end
    chk("drain_sw", sw_q.size(), 0);
    chk("drain_oth", oth_q.size(), 0);
  endtask

  initial begin
    logic [3:0] fts [6];
    logic [7:0] sz;
    int         np;
    fts[0] = 4'd6; fts[1] = 4'd2; fts[2] = 4'd5; fts[3] = 4'd10; fts[4] = 4'd11; fts[5] = 4'd6;
    AXIS_ARESET = 1; S_AXIS_TVALID = 0; S_AXIS_TDATA = '0; S_AXIS_TLAST = 0;
    repeat (3) begin @(posedge clk); #1; end
    AXIS_ARESET = 0;
    @(posedge clk); #1;

    send_pkt(4'd6, 8'h1F, 4, 2);
    chk("t1_sw_cnt", sw_pkt_cnt, 1);
    chk("t1_len_err", len_err_cnt, 0);

    send_pkt(4'd5, 8'h07, 2, 0);
    send_pkt(4'd6, 8'h0F, 2, 3);
    chk("t2_oth_cnt", oth_pkt_cnt, 1);
    chk("t2_sw_cnt", sw_pkt_cnt, 2);

    rdy_mode = 2;
    send_pkt(4'd6, 8'h17, 3, 4);
    drain();

    send_pkt(4'd6, 8'h0F, 3, 2);
    chk("t4_len_err", len_err_cnt, LENCHK ? 1 : 0);

    send_beat(mk_hdr(4'd6, 8'h3F), 0);
    send_beat(rnd64(), 0);
    send_beat(rnd64(), 0);
    do_reset(2);
    send_pkt(4'd10, 8'h00, 0, 2);
    chk("t5_oth_cnt", oth_pkt_cnt, 1);
    chk("t5_sw_cnt", sw_pkt_cnt, 0);

    for (int i = 0; i < 17; i++) send_pkt(4'd10, 8'h00, 0, 0);
    @(posedge clk); #1;
    chk("t6_oth_sat", oth_pkt_cnt, 15);
    drain();

    for (int g = 0; g < 8; g++) begin
      do_reset(2);
      rdy_mode = $urandom_range(0, 1);
      for (int p = 0; p < 12; p++) begin
        sz = 8'($urandom_range(0, 255));
        np = ($urandom_range(0, 1) == 1) ? (int'(sz) >> 3) + 1 : $urandom_range(0, 5);
        send_pkt(fts[$urandom_range(0, 5)], sz, np, $urandom_range(0, 2));
      end
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout act=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
